// File: rtl/porta_pkg.sv
// Shared types and constants for the door-controller output monitor.
package porta_pkg;

   // Tracked door state, encoded as it appears on the estado output.
   typedef enum logic [1:0] {
      FECHADO  = 2'd0,
      ABRINDO  = 2'd1,
      ABERTO   = 2'd2,
      FECHANDO = 2'd3
   } estado_t;

   // Classification of one sample; the low two bits match estado_t for legal classes.
   typedef enum logic [2:0] {
      C_FECHADO  = 3'd0,
      C_ABRINDO  = 3'd1,
      C_ABERTO   = 3'd2,
      C_FECHANDO = 3'd3,
      C_INVALIDO = 3'd4
   } classe_t;

   // 7-segment letters, active-low, segment order {g..a}.
   localparam logic [6:0] HEX_F = 7'b0001110;
   localparam logic [6:0] HEX_O = 7'b1000000;
   localparam logic [6:0] HEX_A = 7'b0001000;

   localparam logic [1:0] ERR_NENHUM    = 2'd0;
   localparam logic [1:0] ERR_PADRAO    = 2'd1;
   localparam logic [1:0] ERR_TRANSICAO = 2'd2;
   localparam logic [1:0] ERR_TEMPO     = 2'd3;

   // Legal moves: hold, advance around the cycle, or reopen from FECHANDO.
   function automatic logic transicao_legal(estado_t de, estado_t para);
      logic ok;
      ok = (de == para);
      case (de)
         FECHADO:  ok = ok || (para == ABRINDO);
         ABRINDO:  ok = ok || (para == ABERTO);
         ABERTO:   ok = ok || (para == FECHANDO);
         FECHANDO: ok = ok || (para == FECHADO) || (para == ABRINDO);
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/porta_classificador.sv
// Combinational decode of {HEX, green LED, red LED} into a door-state class.
module porta_classificador
   import porta_pkg::*;
(
   input  logic [6:0] hex,
   input  logic       verde,
   input  logic       vermelho,
   output classe_t    classe
);

   // Exact match against the four legal patterns; anything else is INVALIDO.
   always_comb begin
      classe = C_INVALIDO;
      if      (hex == HEX_F && !verde &&  vermelho) classe = C_FECHADO;
      else if (hex == HEX_O &&  verde &&  vermelho) classe = C_ABRINDO;
      else if (hex == HEX_A &&  verde && !vermelho) classe = C_ABERTO;
      else if (hex == HEX_O && !verde && !vermelho) classe = C_FECHANDO;
   end

endmodule

// File: rtl/porta_monitor.sv
// Passive checker for the door controller outputs: tracks state, flags errors, counts cycles.
//
//   state    | meaning
//   FECHADO  | door closed, "F" on display, red LED
//   ABRINDO  | opening, "O", both LEDs, dwell-limited
//   ABERTO   | open, "A", green LED
//   FECHANDO | closing, "O", no LEDs, dwell-limited
module porta_monitor
   import porta_pkg::*;
#(
   parameter int MAX_DWELL = 200,
   parameter int DWELL_W   = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         ledVerde,
   input  logic         ledVermelho,
   input  logic [6:0]   HEX,
   input  logic         limpa,
   output logic [1:0]   estado,
   output logic         valido,
   output logic         erro,
   output logic [1:0]   cod_erro,
   output logic [7:0]   ciclos
);

   localparam logic [DWELL_W-1:0] DWELL_LIM = DWELL_W'(MAX_DWELL - 1);
   localparam logic [DWELL_W-1:0] DWELL_SAT = '1;
   localparam logic [DWELL_W-1:0] DWELL_UM  = DWELL_W'(1);

   logic [6:0]         s_hex;
   logic               s_verde, s_vermelho;
   logic               cheio;
   classe_t            classe;

   estado_t            est, est_nxt;
   logic               val_nxt, erro_nxt, raise;
   logic [1:0]         cod_nxt, code;
   logic [7:0]         cic_nxt;
   logic [DWELL_W-1:0] dwell, dwell_nxt;

   // Sample register; cheio marks that it holds a real sample rather than the reset value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s_hex      <= HEX_F;
         s_verde    <= 1'b0;
         s_vermelho <= 1'b1;
         cheio      <= 1'b0;
      end else begin
         s_hex      <= HEX;
         s_verde    <= ledVerde;
         s_vermelho <= ledVermelho;
         cheio      <= 1'b1;
      end
   end

   porta_classificador u_classificador (
      .hex      (s_hex),
      .verde    (s_verde),
      .vermelho (s_vermelho),
      .classe   (classe)
   );

   // Next state, dwell, cycle count and error latch; lowest error code wins a same-cycle tie.
   always_comb begin
      est_nxt   = est;
      val_nxt   = valido;
      cic_nxt   = ciclos;
      dwell_nxt = dwell;
      raise     = 1'b0;
      code      = ERR_NENHUM;
      erro_nxt  = erro;
      cod_nxt   = cod_erro;
      if (cheio) begin
         if (classe == C_INVALIDO) begin
            raise = 1'b1;
            code  = ERR_PADRAO;
         end else begin
            est_nxt = estado_t'(classe[1:0]);
            val_nxt = 1'b1;
            if (valido) begin
               if (!transicao_legal(est, est_nxt)) begin
                  raise = 1'b1;
                  code  = ERR_TRANSICAO;
               end
               if (est == FECHANDO && est_nxt == FECHADO)
                  cic_nxt = ciclos + 8'd1;
            end
         end
         if (est_nxt != est) begin
            dwell_nxt = '0;
         end else if (dwell != DWELL_SAT) begin
            dwell_nxt = dwell + DWELL_UM;
            // Crossing the limit happens once per entry, so this fires only once.
            if (dwell == DWELL_LIM && (est == ABRINDO || est == FECHANDO) && !raise) begin
               raise = 1'b1;
               code  = ERR_TEMPO;
            end
         end
      end
      if (raise) begin
         erro_nxt = 1'b1;
         if (!erro || limpa) cod_nxt = code;
      end else if (limpa) begin
         erro_nxt = 1'b0;
         cod_nxt  = ERR_NENHUM;
      end
   end

   // Tracking state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         est      <= FECHADO;
         valido   <= 1'b0;
         erro     <= 1'b0;
         cod_erro <= ERR_NENHUM;
         ciclos   <= 8'd0;
         dwell    <= '0;
      end else begin
         est      <= est_nxt;
         valido   <= val_nxt;
         erro     <= erro_nxt;
         cod_erro <= cod_nxt;
         ciclos   <= cic_nxt;
         dwell    <= dwell_nxt;
      end
   end

   assign estado = est;

endmodule

// File: tb/tb_porta_monitor.sv
// Scoreboard bench for porta_monitor: directed scenarios followed by a random walk.
module tb_porta_monitor;

   localparam int MAXD = 10;

   // {HEX, ledVerde, ledVermelho} for FECHADO, ABRINDO, ABERTO, FECHANDO.
   localparam logic [8:0] PAT [4] = '{9'b0001110_0_1, 9'b1000000_1_1,
                                      9'b0001000_1_0, 9'b1000000_0_0};
   localparam logic [8:0] INV = 9'b1111111_0_1;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       ledVerde, ledVermelho, limpa;
   logic [6:0] HEX;
   logic [1:0] estado, cod_erro;
   logic       valido, erro;
   logic [7:0] ciclos;

   porta_monitor #(.MAX_DWELL(MAXD), .DWELL_W(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ledVerde    (ledVerde),
      .ledVermelho (ledVermelho),
      .HEX         (HEX),
      .limpa       (limpa),
      .estado      (estado),
      .valido      (valido),
      .erro        (erro),
      .cod_erro    (cod_erro),
      .ciclos      (ciclos)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] est;
      logic       val;
      logic       err;
      logic [1:0] cod;
      logic [7:0] cic;
   } exp_t;

   exp_t q[$];
   event chk_ev;
   int   total = 0;
   int   bad = 0;

   // reference model state
   int         m_est, m_dwell, m_cod;
   bit         m_val, m_erro, p_loaded;
   logic [7:0] m_cic;
   logic [8:0] p_pat;

   function automatic int cls_of(logic [8:0] p);
      for (int i = 0; i < 4; i++) if (p == PAT[i]) return i;
      return 4;
   endfunction

   // cyclic order 0->1->2->3->0 plus reopen 3->1, or hold
   function automatic bit legal(int a, int b);
      return (a == b) || (b == (a + 1) % 4) || (a == 3 && b == 1);
   endfunction

   task automatic model_reset();
      m_est = 0; m_val = 0; m_erro = 0; m_cod = 0; m_cic = 8'd0; m_dwell = 0;
      p_loaded = 0; p_pat = PAT[0];
   endtask

   task automatic push_exp();
      exp_t e;
      e.est = 2'(m_est); e.val = m_val; e.err = m_erro; e.cod = 2'(m_cod); e.cic = m_cic;
      q.push_back(e);
   endtask

   // One clock edge: judge the sample captured at the previous edge, then capture p.
   task automatic model_edge(input logic [8:0] p, input logic lp);
      int c, nw, code;
      code = 0;
      if (p_loaded) begin
         c  = cls_of(p_pat);
         nw = m_est;
         if (c == 4) code = 1;
         else begin
            if (m_val) begin
               if (!legal(m_est, c)) code = 2;
               if (m_est == 3 && c == 0) m_cic = m_cic + 8'd1;
            end
            m_val = 1;
            nw = c;
         end
         if (nw != m_est) m_dwell = 0;
         else if (m_dwell < 255) begin
            m_dwell++;
            if (m_dwell == MAXD && (m_est == 1 || m_est == 3) && code == 0) code = 3;
         end
         m_est = nw;
      end
      if (code != 0) begin
         if (!m_erro || lp) m_cod = code;
         m_erro = 1;
      end else if (lp) begin
         m_erro = 0;
         m_cod  = 0;
      end
      p_pat = p;
      p_loaded = 1;
   endtask

   task automatic apply(input logic [8:0] p, input logic lp);
      {HEX, ledVerde, ledVermelho} = p;
      limpa = lp;
      @(posedge clock);
      model_edge(p, lp);
      push_exp();
      #1;
   endtask

   task automatic hold(input int s, input int n);
      for (int i = 0; i < n; i++) apply(PAT[s], 1'b0);
   endtask

   task automatic async_reset();
      #5;
      reset_n = 1'b0;
      #1;
      model_reset();
      push_exp();
      -> chk_ev;
      #1;
      reset_n = 1'b1;
   endtask

   task automatic cmp(input string n, input logic [7:0] a, input logic [7:0] r);
      total++;
      if (a !== r) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at t=%0t", n, a, r, $time);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare on each negedge or reset check.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock or chk_ev);
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp("estado",   {6'd0, estado},   {6'd0, e.est});
            cmp("valido",   {7'd0, valido},   {7'd0, e.val});
            cmp("erro",     {7'd0, erro},     {7'd0, e.err});
            cmp("cod_erro", {6'd0, cod_erro}, {6'd0, e.cod});
            cmp("ciclos",   ciclos,           e.cic);
         end
      end
   end

   initial begin
      int cur, nxt, len;
      {HEX, ledVerde, ledVermelho} = PAT[0];
      limpa = 1'b0;
      model_reset();
      #2;
      push_exp();
      -> chk_ev;
      #1;
      reset_n = 1'b1;

      hold(0, 3);
      for (int r = 0; r < 256; r++)
         for (int s = 0; s < 4; s++) hold(s, 4);

      // illegal FECHADO->ABERTO, then invalid pattern, then clear
      hold(0, 2);
      hold(2, 3);
      repeat (2) apply(INV, 1'b0);
      apply(INV, 1'b1);
      repeat (2) apply(INV, 1'b0);
      hold(2, 2);
      apply(PAT[2], 1'b1);
      hold(2, 2);

      // dwell timeout in ABRINDO, single raise
      hold(3, 3);
      hold(0, 3);
      hold(1, 14);
      apply(PAT[1], 1'b1);
      hold(1, 12);

      // reopen, then reset mid-ABERTO
      hold(2, 3);
      hold(3, 3);
      hold(1, 3);
      hold(2, 3);
      async_reset();
      hold(0, 2);

      // random walk, mostly legal
      cur = 0;
      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 9) == 0) nxt = $urandom_range(0, 3);
         else if (cur == 3 && $urandom_range(0, 2) == 0) nxt = 1;
         else nxt = (cur + 1) % 4;
         cur = nxt;
         len = $urandom_range(1, 14);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 19) == 0) apply(9'($urandom), $urandom_range(0, 7) == 0);
            else apply(PAT[cur], $urandom_range(0, 7) == 0);
         end
      end

      @(negedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
